twofish_mode_engine: RTL and testbench

Streaming block-cipher mode controller wrapped around the existing 128-bit Twofish datapath core. It accepts plaintext or ciphertext blocks over a valid/ready stream and applies ECB, CBC or CTR chaining. It sequences the core's Reset/Start/busy handshake itself and buffers results in a parametrised output FIFO. It sits between the host stream interface and one datapath instance and keeps the core off the host's timing path.

---
 rtl/twofish_mode_engine.sv | 199 +++++++++++++++++++
 tb/tb_twofish_mode_engine.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/twofish_mode_engine.sv
// ECB/CBC/CTR mode controller around one 128-bit Twofish datapath core.
// Sequences the core's Reset/Start/busy handshake and buffers results in a registered FIFO.
module twofish_mode_engine #(
  parameter int OUT_DEPTH = 4,
  parameter int CTR_W     = 32
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         cfg_load,
  output logic         cfg_ready,
  input  logic [1:0]   cfg_mode,
  input  logic         cfg_ende,
  input  logic [127:0] cfg_iv,
  input  logic [127:0] cfg_key,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         core_reset,
  output logic         core_start,
  output logic         core_ende,
  output logic [127:0] core_block,
  output logic [127:0] core_key,
  input  logic [127:0] core_o,
  input  logic         core_busy
);

  localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(OUT_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_CSTART,
    S_WAIT,
    S_PUSH
  } state_t;

  state_t r_state, w_next;

  logic [1:0]   r_mode;
  logic         r_ende;
  logic [127:0] r_key;
  logic [127:0] r_c;
  logic [127:0] r_x;
  logic [127:0] r_r;
  logic         r_seen;
  logic         r_cfgd;
  logic [127:0] r_blk;
  logic         r_cende;

  logic [127:0] r_mem [OUT_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;

  logic         w_ecb, w_cbc, w_ctr;
  logic         w_accept, w_push, w_pop, w_cfg_take;
  logic [127:0] w_blk, w_push_data;
  logic         w_ende;

  // Reserved mode 3 falls back to ECB
  assign w_cbc = (r_mode == 2'd1);
  assign w_ctr = (r_mode == 2'd2);
  assign w_ecb = !w_cbc && !w_ctr;

  assign cfg_ready  = (r_state == S_IDLE) && (r_count == '0);
  assign in_ready   = (r_state == S_IDLE) && (r_count < DEPTH_C) && r_cfgd;
  assign out_valid  = (r_count != '0);
  assign out_data   = r_mem[r_rptr];
  assign w_accept   = in_valid && in_ready;
  assign w_push     = (r_state == S_PUSH);
  assign w_pop      = out_valid && out_ready;
  assign w_cfg_take = cfg_load && cfg_ready;

  assign core_reset = (r_state == S_CRST);
  assign core_start = (r_state == S_CSTART);
  assign core_key   = r_key;
  // Block/ende are computed live during CRST, then held in r_blk/r_cende
  assign core_block = (r_state == S_CRST) ? w_blk  : r_blk;
  assign core_ende  = (r_state == S_CRST) ? w_ende : r_cende;

  always_comb begin
    w_blk  = r_x;
    w_ende = r_ende;
    if (w_cbc && !r_ende) begin
      w_blk = r_x ^ r_c;
    end else if (w_ctr) begin
      w_blk  = r_c;
      w_ende = 1'b0;
    end
  end

  always_comb begin
    w_push_data = r_r;
    if (w_cbc && r_ende) begin
      w_push_data = r_r ^ r_c;
    end else if (w_ctr) begin
      w_push_data = r_r ^ r_x;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_CRST;
      S_CRST:   w_next = S_CSTART;
      S_CSTART: w_next = S_WAIT;
      S_WAIT:   if (!core_busy && r_seen) w_next = S_PUSH;
      S_PUSH:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_mode  <= '0;
      r_ende  <= 1'b0;
      r_key   <= '0;
      r_c     <= '0;
      r_x     <= '0;
      r_r     <= '0;
      r_seen  <= 1'b0;
      r_cfgd  <= 1'b0;
      r_blk   <= '0;
      r_cende <= 1'b0;
    end else begin
      if (w_cfg_take) begin
        r_mode <= cfg_mode;
        r_ende <= cfg_ende;
        r_key  <= cfg_key;
        r_c    <= cfg_iv;
        r_cfgd <= 1'b1;
      end
      if (w_accept) begin
        r_x <= in_data;
      end
      case (r_state)
        S_CRST: begin
          r_blk   <= w_blk;
          r_cende <= w_ende;
          r_seen  <= 1'b0;
        end
        S_WAIT: begin
          // Result is only trusted on a busy high-to-low transition
          if (core_busy) begin
            r_seen <= 1'b1;
          end else if (r_seen) begin
            r_r <= core_o;
          end
        end
        S_PUSH: begin
          if (w_cbc && !r_ende) begin
            r_c <= r_r;
          end else if (w_cbc && r_ende) begin
            r_c <= r_x;
          end else if (w_ctr) begin
            r_c[CTR_W-1:0] <= r_c[CTR_W-1:0] + CTR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < unsigned'(OUT_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_push_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_twofish_mode_engine.sv
// Directed bench for twofish_mode_engine with a behavioural stand-in for the datapath core.
// The stand-in is a keyed 128-bit permutation whose E(0) under key 0 equals the Twofish reference vector.
module tb_twofish_mode_engine;

  localparam int LAT = 3;
  localparam logic [127:0] E0  = 128'h9F589F5CF6122C32B6BFEC2F2AE8C35A;
  localparam logic [127:0] K1  = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] K2  = 128'h55AA55AA00FF00FF12345678CAFEBABE;
  localparam logic [127:0] IV1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] X1  = 128'hDEADBEEF0BADF00DFEEDFACE13572468;
  localparam logic [127:0] X2  = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  localparam logic [127:0] WIV = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_FFFFFFFF;
  localparam logic [127:0] WLO = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_00000000;

  logic         clk, rst;
  logic         cfg_load, cfg_ready, cfg_ende;
  logic [1:0]   cfg_mode;
  logic [127:0] cfg_iv, cfg_key;
  logic         in_valid, in_ready;
  logic [127:0] in_data;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic         core_reset, core_start, core_ende, core_busy;
  logic [127:0] core_block, core_key, core_o;

  int checks = 0;
  int errors = 0;

  twofish_mode_engine #(.OUT_DEPTH(4), .CTR_W(32)) dut (
    .Clk(clk), .Reset(rst),
    .cfg_load(cfg_load), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode), .cfg_ende(cfg_ende),
    .cfg_iv(cfg_iv), .cfg_key(cfg_key),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_reset(core_reset), .core_start(core_start), .core_ende(core_ende),
    .core_block(core_block), .core_key(core_key), .core_o(core_o), .core_busy(core_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] te(input logic [127:0] k, input logic [127:0] x);
    logic [127:0] t;
    t = x ^ k;
    return {t[114:0], t[127:115]} ^ E0;
  endfunction

  function automatic logic [127:0] td(input logic [127:0] k, input logic [127:0] y);
    logic [127:0] t;
    t = y ^ E0;
    return {t[12:0], t[127:13]} ^ k;
  endfunction

  // Core stand-in: busy rises one cycle after Start, stays high LAT cycles, result appears as busy falls
  logic [127:0] m_blk, m_key;
  logic         m_ende;
  int           m_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_busy <= 1'b0; m_cnt <= 0; core_o <= '0;
      m_blk <= '0; m_key <= '0; m_ende <= 1'b0;
    end else if (core_reset) begin
      core_busy <= 1'b0; m_cnt <= 0; core_o <= '0;
    end else if (core_start) begin
      m_cnt <= LAT + 1; m_blk <= core_block; m_key <= core_key; m_ende <= core_ende;
      core_o <= 128'hBADBADBADBADBADBADBADBADBADBADBA;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == LAT + 1) core_busy <= 1'b1;
      if (m_cnt == 1) begin
        core_busy <= 1'b0;
        core_o    <= m_ende ? td(m_key, m_blk) : te(m_key, m_blk);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timeout", nm);
  endtask

  task automatic do_cfg(input logic [1:0] m, input logic e, input logic [127:0] iv, input logic [127:0] k);
    cfg_mode = m; cfg_ende = e; cfg_iv = iv; cfg_key = k; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic send(input logic [127:0] d);
    int n;
    in_valid = 1'b1; in_data = d; n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    if (n >= 200) timeout("send");
    else tick();
    in_valid = 1'b0;
  endtask

  task automatic recv(input string nm, input logic [127:0] exp);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    if (n >= 200) timeout(nm);
    else begin
      chk(nm, out_data, exp);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic wait_busy(input logic lvl, input string nm);
    int n;
    n = 0;
    while (core_busy !== lvl && n < 100) begin tick(); n++; end
    if (n >= 100) timeout(nm);
  endtask

  typedef struct {
    logic         cfg;
    logic [1:0]   mode;
    logic         ende;
    logic [127:0] iv;
    logic [127:0] key;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t tv[15];
  logic [127:0] c1, c2;

  initial begin
    clk = 1'b0; rst = 1'b1;
    cfg_load = 1'b0; cfg_mode = '0; cfg_ende = 1'b0; cfg_iv = '0; cfg_key = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    c1 = te(K1, X1 ^ IV1);
    c2 = te(K1, X2 ^ c1);
    tv[0]  = '{1'b1, 2'd0, 1'b0, '0,  '0, '0,          E0};
    tv[1]  = '{1'b1, 2'd0, 1'b1, '0,  '0, E0,          '0};
    tv[2]  = '{1'b1, 2'd1, 1'b0, '0,  '0, '0,          E0};
    tv[3]  = '{1'b0, 2'd1, 1'b0, '0,  '0, '0,          te('0, E0)};
    tv[4]  = '{1'b1, 2'd1, 1'b1, '0,  '0, E0,          '0};
    tv[5]  = '{1'b0, 2'd1, 1'b1, '0,  '0, te('0, E0),  '0};
    tv[6]  = '{1'b1, 2'd2, 1'b0, '0,  '0, '0,          E0};
    tv[7]  = '{1'b0, 2'd2, 1'b0, '0,  '0, '0,          te('0, 128'd1)};
    tv[8]  = '{1'b1, 2'd2, 1'b1, WIV, K1, X1,          te(K1, WIV) ^ X1};
    tv[9]  = '{1'b0, 2'd2, 1'b1, WIV, K1, X2,          te(K1, WLO) ^ X2};
    tv[10] = '{1'b1, 2'd3, 1'b1, '0,  K1, X1,          td(K1, X1)};
    tv[11] = '{1'b1, 2'd1, 1'b0, IV1, K1, X1,          c1};
    tv[12] = '{1'b0, 2'd1, 1'b0, IV1, K1, X2,          c2};
    tv[13] = '{1'b1, 2'd1, 1'b1, IV1, K1, c1,          X1};
    tv[14] = '{1'b0, 2'd1, 1'b1, IV1, K1, c2,          X2};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cfg_ready", {127'd0, cfg_ready}, 128'd1);
    chk("rst_in_ready",  {127'd0, in_ready},  128'd0);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_core_reset", {127'd0, core_reset}, 128'd0);
    chk("rst_core_start", {127'd0, core_start}, 128'd0);
    chk("rst_core_ende", {127'd0, core_ende}, 128'd0);
    chk("rst_core_block", core_block, '0);
    chk("rst_core_key", core_key, '0);
    rst = 1'b0;
    tick();
    chk("unconfigured_in_ready", {127'd0, in_ready}, 128'd0);

    // Handshake latency and CBC-encrypt block formation
    do_cfg(2'd1, 1'b0, IV1, K1);
    in_data = X1; in_valid = 1'b1;
    chk("lat_in_ready", {127'd0, in_ready}, 128'd1);
    tick();
    in_valid = 1'b0;
    chk("lat_core_reset", {127'd0, core_reset}, 128'd1);
    chk("lat_no_start", {127'd0, core_start}, 128'd0);
    chk("lat_block_crst", core_block, X1 ^ IV1);
    chk("lat_ende_crst", {127'd0, core_ende}, 128'd0);
    chk("lat_core_key", core_key, K1);
    tick();
    chk("lat_reset_drop", {127'd0, core_reset}, 128'd0);
    chk("lat_core_start", {127'd0, core_start}, 128'd1);
    chk("lat_block_start", core_block, X1 ^ IV1);
    tick();
    chk("lat_start_drop", {127'd0, core_start}, 128'd0);
    chk("lat_block_hold", core_block, X1 ^ IV1);
    wait_busy(1'b1, "lat_busy_rise");
    wait_busy(1'b0, "lat_busy_fall");
    chk("lat_ov_fall", {127'd0, out_valid}, 128'd0);
    tick();
    chk("lat_ov_push", {127'd0, out_valid}, 128'd0);
    tick();
    chk("lat_ov_rise", {127'd0, out_valid}, 128'd1);
    recv("lat_data", c1);

    // Table of single-block transactions across modes
    for (int i = 0; i < 15; i++) begin
      if (tv[i].cfg) do_cfg(tv[i].mode, tv[i].ende, tv[i].iv, tv[i].key);
      send(tv[i].din);
      recv($sformatf("vec%0d", i), tv[i].exp);
    end

    // cfg_load during WAIT must be ignored
    do_cfg(2'd0, 1'b0, '0, K1);
    send(X2);
    wait_busy(1'b1, "ign_busy");
    chk("ign_cfg_ready", {127'd0, cfg_ready}, 128'd0);
    cfg_mode = 2'd2; cfg_ende = 1'b1; cfg_iv = IV1; cfg_key = K2; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("ign_core_key", core_key, K1);
    recv("ign_data0", te(K1, X2));
    send(X1);
    recv("ign_data1", te(K1, X1));

    // Backpressure: fill FIFO, pop one, overlap push with pop
    do_cfg(2'd0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) send(128'h1000 + 128'(i));
    repeat (15) tick();
    chk("bp_full_in_ready", {127'd0, in_ready}, 128'd0);
    chk("bp_full_cfg_ready", {127'd0, cfg_ready}, 128'd0);
    chk("bp_head", out_data, te('0, 128'h1000));
    in_valid = 1'b1; in_data = 128'h1004;
    repeat (3) tick();
    chk("bp_head_stable", out_data, te('0, 128'h1000));
    chk("bp_blocked", {127'd0, in_ready}, 128'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_space_after_pop", {127'd0, in_ready}, 128'd1);
    chk("bp_head_after_pop", out_data, te('0, 128'h1001));
    tick();
    in_valid = 1'b0;
    wait_busy(1'b1, "bp_busy_rise");
    wait_busy(1'b0, "bp_busy_fall");
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_pushpop_head", out_data, te('0, 128'h1002));
    chk("bp_pushpop_space", {127'd0, in_ready}, 128'd1);
    send(128'h1005);
    repeat (15) tick();
    chk("bp_full_again", {127'd0, in_ready}, 128'd0);
    for (int i = 2; i < 6; i++) recv($sformatf("bp_drain%0d", i), te('0, 128'h1000 + 128'(i)));
    chk("bp_empty", {127'd0, out_valid}, 128'd0);
    chk("bp_cfg_ready", {127'd0, cfg_ready}, 128'd1);

    // Asynchronous reset while a block is in WAIT with one entry buffered
    do_cfg(2'd0, 1'b0, '0, '0);
    send(X1);
    send(X2);
    wait_busy(1'b1, "ar_busy");
    chk("ar_pre_valid", {127'd0, out_valid}, 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_core_reset", {127'd0, core_reset}, 128'd0);
    chk("ar_core_start", {127'd0, core_start}, 128'd0);
    tick();
    chk("ar_out_valid", {127'd0, out_valid}, 128'd0);
    chk("ar_cfg_ready", {127'd0, cfg_ready}, 128'd1);
    chk("ar_in_ready", {127'd0, in_ready}, 128'd0);
    rst = 1'b0;
    tick();
    chk("ar_post_in_ready", {127'd0, in_ready}, 128'd0);
    do_cfg(2'd0, 1'b0, '0, '0);
    send('0);
    recv("ar_ecb0", E0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
